// File: rtl/execute_stage.sv
// EX stage: operand forwarding, ALU, iterative shift-add multiplier and the
// EX/MEM pipeline register that feeds the memory stage.
module execute_stage #(
    parameter int WIDTH     = 32,
    parameter int MUL_ITERS = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] rsData_ex,
    input  logic [WIDTH-1:0] rtData_ex,
    input  logic [WIDTH-1:0] imm_ex,
    input  logic [4:0]       Rs_ex,
    input  logic [4:0]       Rt_ex,
    input  logic [4:0]       Rd_ex,
    input  logic [2:0]       ALUOp,
    input  logic             ALUSrc,
    input  logic             Mul_ex,
    input  logic             MemWrite_ex,
    input  logic             MemToReg_ex,
    input  logic             RegWrite_ex,
    input  logic [WIDTH-1:0] memAddr_fwd,
    input  logic [WIDTH-1:0] writeData_fwd,
    input  logic [4:0]       dest_mem,
    input  logic [4:0]       dest_wb,
    input  logic             RegWrite_mem,
    input  logic             RegWrite_wb,
    output logic [WIDTH-1:0] memAddr,
    output logic [WIDTH-1:0] storedRt2,
    output logic [4:0]       Rt_mem,
    output logic [4:0]       Rd_mem,
    output logic             MemWrite,
    output logic             MemToReg,
    output logic             RegWrite,
    output logic             stall,
    output logic [1:0]       mulState
);

    localparam int SH_W  = $clog2(WIDTH);
    localparam int CNT_W = $clog2(MUL_ITERS + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MUL_ITERS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mulState_t;

    mulState_t        state;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] iterCount;

    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] fwdRt;
    logic [WIDTH-1:0] opB;
    logic [WIDTH-1:0] aluResult;

    // MEM holds the younger result, so it wins over WB; $0 is never forwarded.
    always_comb begin
        opA = rsData_ex;
        if (RegWrite_mem && dest_mem == Rs_ex && Rs_ex != 5'd0)
            opA = memAddr_fwd;
        else if (RegWrite_wb && dest_wb == Rs_ex && Rs_ex != 5'd0)
            opA = writeData_fwd;

        fwdRt = rtData_ex;
        if (RegWrite_mem && dest_mem == Rt_ex && Rt_ex != 5'd0)
            fwdRt = memAddr_fwd;
        else if (RegWrite_wb && dest_wb == Rt_ex && Rt_ex != 5'd0)
            fwdRt = writeData_fwd;
    end

    assign opB = ALUSrc ? imm_ex : fwdRt;

    always_comb begin
        aluResult = '0;
        case (ALUOp)
            3'b000: aluResult = opA + opB;
            3'b001: aluResult = opA - opB;
            3'b010: aluResult = opA & opB;
            3'b011: aluResult = opA | opB;
            3'b100: aluResult = opA ^ opB;
            3'b101: aluResult = {{(WIDTH-1){1'b0}}, ($signed(opA) < $signed(opB))};
            3'b110: aluResult = opA << opB[SH_W-1:0];
            3'b111: aluResult = ~(opA | opB);
            default: aluResult = '0;
        endcase
    end

    // stall: while high, PC, IF/ID and ID/EX must hold; EX/MEM keeps advancing
    // and receives bubbles, so the instruction in EX is re-presented until DONE.
    assign stall    = !reset && ((state == IDLE && Mul_ex) || state == BUSY);
    assign mulState = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            iterCount <= '0;
            memAddr   <= '0;
            storedRt2 <= '0;
            Rt_mem    <= '0;
            Rd_mem    <= '0;
            MemWrite  <= 1'b0;
            MemToReg  <= 1'b0;
            RegWrite  <= 1'b0;
        end else begin
            // Bubble by default; only a completing instruction overrides.
            memAddr   <= '0;
            storedRt2 <= '0;
            Rt_mem    <= '0;
            Rd_mem    <= '0;
            MemWrite  <= 1'b0;
            MemToReg  <= 1'b0;
            RegWrite  <= 1'b0;
            case (state)
                IDLE: begin
                    if (Mul_ex) begin
                        mcand     <= opA;
                        mplier    <= opB;
                        acc       <= '0;
                        iterCount <= '0;
                        state     <= BUSY;
                    end else begin
                        memAddr   <= aluResult;
                        storedRt2 <= fwdRt;
                        Rt_mem    <= Rt_ex;
                        Rd_mem    <= Rd_ex;
                        MemWrite  <= MemWrite_ex;
                        MemToReg  <= MemToReg_ex;
                        RegWrite  <= RegWrite_ex;
                    end
                end
                BUSY: begin
                    if (mplier[0])
                        acc <= acc + mcand;
                    mcand     <= mcand << 1;
                    mplier    <= mplier >> 1;
                    iterCount <= iterCount + 1'b1;
                    if (iterCount == LAST_ITER)
                        state <= DONE;
                end
                DONE: begin
                    memAddr   <= acc;
                    storedRt2 <= fwdRt;
                    Rt_mem    <= Rt_ex;
                    Rd_mem    <= Rd_ex;
                    MemWrite  <= MemWrite_ex;
                    MemToReg  <= MemToReg_ex;
                    RegWrite  <= RegWrite_ex;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- EX stage of the 5-stage pipelined CPU; sits directly upstream of the memory stage.
- Resolves operand forwarding from the EX/MEM and MEM/WB stages, selects the register or immediate operand, and computes the ALU result.
- Runs an iterative 32-cycle shift-add multiplier that stalls the front end while busy.
- Registers results into the EX/MEM pipeline register that feeds the memory stage (memAddr, storedRt2, Rt_mem, Rd_mem, MemWrite, MemToReg).

Parameters:
- WIDTH, 32, datapath width.
- MUL_ITERS, 32, multiplier iterations; must equal WIDTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high.
- rsData_ex  input  32  Rs value from ID/EX.
- rtData_ex  input  32  Rt value from ID/EX.
- imm_ex  input  32  sign-extended immediate.
- Rs_ex, Rt_ex, Rd_ex  input  5 each  register numbers from ID/EX.
- ALUOp  input  3  ALU operation select.
- ALUSrc  input  1  1 = operand B is imm_ex.
- Mul_ex  input  1  instruction in EX is MUL.
- MemWrite_ex, MemToReg_ex, RegWrite_ex  input  1 each  control from ID/EX.
- memAddr_fwd  input  32  EX/MEM ALU result, equal to memAddr.
- writeData_fwd  input  32  MEM-stage writeback value.
- dest_mem, dest_wb  input  5 each  destination register of the instruction in MEM and WB.
- RegWrite_mem, RegWrite_wb  input  1 each  write enables for those destinations.
- memAddr  output  32  registered ALU/MUL result.
- storedRt2  output  32  registered, forwarded Rt value (store data).
- Rt_mem, Rd_mem  output  5 each  registered Rt_ex/Rd_ex.
- MemWrite, MemToReg, RegWrite  output  1 each  registered control.
- stall  output  1  hold PC, IF/ID and ID/EX this cycle.

Behaviour:
- Reset (synchronous, high): all registered outputs = 0; FSM → IDLE; iteration counter = 0; stall = 0. Reset in any FSM state aborts a multiply with no writeback.
- Forwarding, applied separately to Rs (→ opA) and Rt (→ fwdRt):
  - If RegWrite_mem and dest_mem == reg and reg != 0, use memAddr_fwd.
  - Else if RegWrite_wb and dest_wb == reg and reg != 0, use writeData_fwd.
  - Else use the ID/EX value. MEM has priority over WB.
- opB = ALUSrc ? imm_ex : fwdRt. storedRt2 always captures fwdRt.
- ALUOp encoding:
  - 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 111 NOR.
  - 101 SLT: signed; result is 1 or 0, zero-extended.
  - 110 SLL: opA << opB[4:0].
  - Add and subtract wrap modulo 2^32; no overflow flag.
- Latency: non-MUL instructions take 1 cycle. Their result appears on memAddr after the rising edge ending the EX cycle.
- MUL FSM (IDLE, BUSY, DONE); result is the low 32 bits of opA*opB (unsigned shift-add; low bits are sign-agnostic).
  - IDLE & Mul_ex:
    - stall = 1 combinationally.
    - Capture opA into the multiplicand, opB into the multiplier; clear the accumulator and counter.
    - → BUSY.
    - EX/MEM loads a bubble: MemWrite = MemToReg = RegWrite = 0, data and register fields 0.
  - BUSY: stall = 1 and EX/MEM loads a bubble each cycle.
    - Each cycle: if multiplier[0], add the multiplicand to the accumulator; shift the multiplicand left 1, the multiplier right 1; counter++.
    - After iteration MUL_ITERS → DONE.
  - DONE: stall = 0.
    - EX/MEM loads accumulator → memAddr, with that instruction's Rt/Rd/control from ID/EX (still held).
    - → IDLE.
  - Total: stall high for MUL_ITERS+1 cycles; the product is on memAddr at the edge ending cycle MUL_ITERS+1, counting from the start cycle as 0.
- Operands are captured at start, so forwarding-source changes during BUSY have no effect.
- MUL in DONE is never restarted: the FSM returns to IDLE, and ID/EX advances the same edge.
- Back-to-back MULs: a second MUL presented in the cycle after DONE starts normally.

Test Plan:
- ADD, no hazard: rsData=5, rtData=7, ALUOp=000, ALUSrc=0, RegWrite_ex=1 → next edge memAddr=12, RegWrite=1, stall=0.
- Forward priority: Rs_ex=3, dest_mem=3, dest_wb=3, both RegWrite=1, memAddr_fwd=100, writeData_fwd=200, ADD imm 1 → memAddr=101. Same with dest_mem=0 and Rs_ex=0 → memAddr=rsData+1, with no forwarding for $0.
- Store-data forward: Rt_ex=4, dest_wb=4, RegWrite_wb=1, writeData_fwd=0xDEADBEEF, ALUSrc=1, MemWrite_ex=1 → storedRt2=0xDEADBEEF, memAddr=rsData+imm, MemWrite=1.
- SLT signed: opA=0xFFFFFFFF, opB=1 → memAddr=1. Swap operands → 0.
- MUL 7×6: stall high exactly 33 cycles with MemWrite=RegWrite=0 throughout. On the next edge memAddr=42, RegWrite=1. Also 0xFFFFFFFF×2 → 0xFFFFFFFE.
- Reset mid-MUL: assert reset in BUSY iteration 10 → next edge all outputs 0, stall=0, FSM IDLE; no product is ever written.
